gfx_cmd_queue: RTL and testbench

Parametrised successor to the graphics command decoder, sitting between the APB-style command port and the line/clear renderer. It queues incoming 32-bit commands in a DEPTH-entry FIFO and executes them strictly in order. Register commands (set/move start/end, colour) update the coordinate and colour registers. Render commands (draw, clear, flip) are held while the renderer is busy. Move commands are signed relative moves, clamped to the screen bounds.

---
 rtl/gfx_cmd_pkg.sv | 28 ++
 rtl/cmd_fifo.sv | 48 ++++
 rtl/gfx_cmd_queue.sv | 132 +++++++++++++
 tb/tb_gfx_cmd_queue.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gfx_cmd_pkg.sv
// Shared opcode, field-position and FSM definitions for the graphics command queue.
package gfx_cmd_pkg;

    localparam int unsigned CMD_W      = 32;
    localparam int unsigned RSVD_LSB   = 27;
    localparam int unsigned OPCODE_LSB = 24;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned DATA_W     = 24;
    localparam int unsigned ENTRY_W    = OP_W + DATA_W;

    typedef enum logic [OP_W-1:0] {
        OP_CLEAR      = 3'b000,
        OP_SET_START  = 3'b001,
        OP_SET_END    = 3'b010,
        OP_COLOR      = 3'b011,
        OP_MOVE_START = 3'b100,
        OP_MOVE_END   = 3'b101,
        OP_DRAW       = 3'b110,
        OP_FLIP       = 3'b111
    } gfx_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StDispatch,
        StWait
    } gfx_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO; a push and a pop in the same cycle are both honoured, even when full.
module cmd_fifo #(
    parameter int unsigned WIDTH = 27,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: rtl/gfx_cmd_queue.sv
// In-order graphics command queue: register ops update coordinates/colour, render ops
// are issued to the renderer only when it is not busy.
module gfx_cmd_queue
    import gfx_cmd_pkg::*;
#(
    parameter int unsigned X_W   = 9,
    parameter int unsigned Y_W   = 8,
    parameter int unsigned X_MAX = 319,
    parameter int unsigned Y_MAX = 239,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               penable,
    input  logic [CMD_W-1:0]   command_bus,
    input  logic               render_busy,
    output logic [X_W+Y_W-1:0] start,
    output logic [X_W+Y_W-1:0] end1,
    output logic [23:0]        color,
    output logic [2:0]         op,
    output logic               received_op,
    output logic               flip_buffer,
    output logic               cmd_ready,
    output logic               overflow,
    output logic               cmd_err
);

    localparam int unsigned XY_W  = X_W + Y_W;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    gfx_state_t         state_q;
    logic               penable_q;
    logic               accept, rsvd_bad, push, pop, full, empty, nonempty_next;
    logic [CNT_W-1:0]   count;
    logic [ENTRY_W-1:0] head;
    gfx_op_t            head_op;
    logic [DATA_W-1:0]  head_data;
    logic               head_is_render;

    assign accept    = penable && !penable_q;
    assign rsvd_bad  = |command_bus[CMD_W-1:RSVD_LSB];
    assign head_op   = gfx_op_t'(head[ENTRY_W-1:DATA_W]);
    assign head_data = head[DATA_W-1:0];
    assign head_is_render = (head_op == OP_CLEAR) || (head_op == OP_DRAW) || (head_op == OP_FLIP);

    assign pop  = (state_q != StIdle) && !empty && (!head_is_render || !render_busy);
    // A full FIFO still takes the new command when the head leaves in the same cycle.
    assign push = accept && !rsvd_bad && (!full || pop);
    assign nonempty_next = push || (count != CNT_W'(pop));
    assign cmd_ready = !full;

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .nrst  (nrst),
        .push  (push),
        .pop   (pop),
        .wdata (command_bus[ENTRY_W-1:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    logic [X_W-1:0] fld_x, set_x, mov_x;
    logic [Y_W-1:0] fld_y, set_y, mov_y;
    logic [XY_W-1:0] base;
    logic [X_W+1:0] sum_x;
    logic [Y_W+1:0] sum_y;

    // Two guard bits so base+delta never wraps before clamping (319+255 exceeds X_W+1 bits).
    always_comb begin
        fld_x = head_data[XY_W-1:Y_W];
        fld_y = head_data[Y_W-1:0];
        set_x = (fld_x > X_LIM) ? X_LIM : fld_x;
        set_y = (fld_y > Y_LIM) ? Y_LIM : fld_y;
        base  = (head_op == OP_MOVE_START) ? start : end1;
        sum_x = {2'b00, base[XY_W-1:Y_W]} + {{2{fld_x[X_W-1]}}, fld_x};
        sum_y = {2'b00, base[Y_W-1:0]} + {{2{fld_y[Y_W-1]}}, fld_y};
        if (sum_x[X_W+1])                  mov_x = '0;
        else if (sum_x[X_W:0] > {1'b0, X_LIM}) mov_x = X_LIM;
        else                               mov_x = sum_x[X_W-1:0];
        if (sum_y[Y_W+1])                  mov_y = '0;
        else if (sum_y[Y_W:0] > {1'b0, Y_LIM}) mov_y = Y_LIM;
        else                               mov_y = sum_y[Y_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= StIdle;
            penable_q   <= 1'b0;
            start       <= '0;
            end1        <= '0;
            color       <= '0;
            op          <= '0;
            received_op <= 1'b0;
            flip_buffer <= 1'b0;
            overflow    <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            penable_q   <= penable;
            received_op <= 1'b0;
            flip_buffer <= 1'b0;
            cmd_err     <= accept && rsvd_bad;
            if (accept && !rsvd_bad && full && !pop) overflow <= 1'b1;

            if (pop) begin
                unique case (head_op)
                    OP_SET_START:  start <= {set_x, set_y};
                    OP_SET_END:    end1  <= {set_x, set_y};
                    OP_COLOR:      color <= head_data;
                    OP_MOVE_START: start <= {mov_x, mov_y};
                    OP_MOVE_END:   end1  <= {mov_x, mov_y};
                    default: begin
                        op          <= head_op;
                        received_op <= 1'b1;
                        flip_buffer <= (head_op == OP_FLIP);
                    end
                endcase
            end

            if (!nonempty_next)                 state_q <= StIdle;
            else if (!empty && !pop && head_is_render) state_q <= StWait;
            else                                state_q <= StDispatch;
        end
    end

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Directed bench for gfx_cmd_queue with hand-computed expectations.
module tb_gfx_cmd_queue;

    logic        clk = 1'b0;
    logic        nrst, penable, render_busy;
    logic [31:0] command_bus;
    logic [16:0] start, end1;
    logic [23:0] color;
    logic [2:0]  op;
    logic        received_op, flip_buffer, cmd_ready, overflow, cmd_err;

    int vectors     = 0;
    int miscompares = 0;

    gfx_cmd_queue #(
        .X_W   (9),
        .Y_W   (8),
        .X_MAX (319),
        .Y_MAX (239),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .penable     (penable),
        .command_bus (command_bus),
        .render_busy (render_busy),
        .start       (start),
        .end1        (end1),
        .color       (color),
        .op          (op),
        .received_op (received_op),
        .flip_buffer (flip_buffer),
        .cmd_ready   (cmd_ready),
        .overflow    (overflow),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [2:0] opc, input logic [8:0] x,
                                       input logic [7:0] y);
        return {5'b0, opc, 7'b0, x, y};
    endfunction

    // Strobe penable for 'hold' cycles; one extra edge lets a register op execute.
    task automatic send(input logic [31:0] cmd, input int hold);
        command_bus = cmd;
        penable     = 1'b1;
        repeat (hold) tick();
        penable = 1'b0;
        tick();
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_start"}, 32'(start), 32'd0);
        check_eq({pfx, "_end1"}, 32'(end1), 32'd0);
        check_eq({pfx, "_color"}, 32'(color), 32'd0);
        check_eq({pfx, "_op"}, 32'(op), 32'd0);
        check_eq({pfx, "_rx"}, 32'(received_op), 32'd0);
        check_eq({pfx, "_flip"}, 32'(flip_buffer), 32'd0);
        check_eq({pfx, "_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({pfx, "_ovf"}, 32'(overflow), 32'd0);
        check_eq({pfx, "_err"}, 32'(cmd_err), 32'd0);
    endtask

    initial begin
        int pulses;
        nrst = 1'b0; penable = 1'b0; render_busy = 1'b0; command_bus = '0;
        tick(); tick();
        nrst = 1'b1;
        tick();
        check_reset("rst");

        // Set start with a 2-cycle strobe.
        send(mk(3'b001, 9'd3, 8'd4), 2);
        check_eq("set_start", 32'(start), 32'({9'd3, 8'd4}));
        check_eq("ready_idle", 32'(cmd_ready), 32'd1);

        // Set end in range, then out of range (clamped).
        send(mk(3'b010, 9'd100, 8'd50), 1);
        check_eq("set_end_mid", 32'(end1), 32'({9'd100, 8'd50}));
        send(mk(3'b010, 9'd319, 8'd239), 1);
        check_eq("set_end_max", 32'(end1), 32'({9'd319, 8'd239}));
        send(mk(3'b010, 9'd50, 8'd60), 1);
        send(mk(3'b010, 9'd400, 8'd250), 1);
        check_eq("set_end_clamp", 32'(end1), 32'({9'd319, 8'd239}));

        // Colour then a one-cycle draw.
        send({5'b0, 3'b011, 24'hFF0000}, 1);
        check_eq("color", 32'(color), 32'hFF0000);
        command_bus = mk(3'b110, 9'd0, 8'd0);
        penable = 1'b1;
        tick();
        check_eq("draw_rx_pre", 32'(received_op), 32'd0);
        penable = 1'b0;
        tick();
        check_eq("draw_rx", 32'(received_op), 32'd1);
        check_eq("draw_op", 32'(op), 32'd6);
        check_eq("draw_flip", 32'(flip_buffer), 32'd0);
        tick();
        check_eq("draw_rx_post", 32'(received_op), 32'd0);

        // A draw strobe held 3 cycles must issue exactly once.
        pulses = 0;
        command_bus = mk(3'b110, 9'd0, 8'd0);
        penable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) penable = 1'b0;
            tick();
            pulses += int'(received_op);
        end
        check_eq("held_strobe_pulses", 32'(pulses), 32'd1);

        // Flip held by busy renderer; register op behind it must wait.
        render_busy = 1'b1;
        send(mk(3'b111, 9'd0, 8'd0), 1);
        send(mk(3'b001, 9'd10, 8'd5), 1);
        tick(); tick();
        check_eq("wait_rx", 32'(received_op), 32'd0);
        check_eq("wait_start", 32'(start), 32'({9'd3, 8'd4}));
        render_busy = 1'b0;
        tick();
        check_eq("flip_rx", 32'(received_op), 32'd1);
        check_eq("flip_pulse", 32'(flip_buffer), 32'd1);
        check_eq("flip_op", 32'(op), 32'd7);
        check_eq("flip_start_old", 32'(start), 32'({9'd3, 8'd4}));
        tick();
        check_eq("after_flip_start", 32'(start), 32'({9'd10, 8'd5}));
        check_eq("after_flip_rx", 32'(received_op), 32'd0);
        check_eq("after_flip_fb", 32'(flip_buffer), 32'd0);

        // Relative moves with clamping.
        send(mk(3'b001, 9'd5, 8'd5), 1);
        send(mk(3'b100, 9'h1F8, 8'd3), 1);
        check_eq("move_start", 32'(start), 32'({9'd0, 8'd8}));
        send(mk(3'b010, 9'd319, 8'd239), 1);
        send(mk(3'b101, 9'd1, 8'hFF), 1);
        check_eq("move_end", 32'(end1), 32'({9'd319, 8'd238}));
        send(mk(3'b101, 9'd255, 8'd127), 1);
        check_eq("move_end_hi", 32'(end1), 32'({9'd319, 8'd239}));

        // Reserved bits: dropped, error pulse, start untouched.
        command_bus = 32'h0900_0000;
        penable = 1'b1;
        tick();
        check_eq("rsvd_err", 32'(cmd_err), 32'd1);
        penable = 1'b0;
        tick();
        check_eq("rsvd_err_clr", 32'(cmd_err), 32'd0);
        check_eq("rsvd_start", 32'(start), 32'({9'd0, 8'd8}));

        // Fill FIFO behind a busy renderer.
        render_busy = 1'b1;
        for (int i = 0; i < 3; i++) send(mk(3'b110, 9'd0, 8'd0), 1);
        check_eq("ready_3", 32'(cmd_ready), 32'd1);
        send(mk(3'b110, 9'd0, 8'd0), 1);
        check_eq("ready_full", 32'(cmd_ready), 32'd0);
        check_eq("ovf_pre", 32'(overflow), 32'd0);
        send(mk(3'b110, 9'd0, 8'd0), 1);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        command_bus = 32'h0800_0000;
        penable = 1'b1;
        tick();
        check_eq("full_rsvd_err", 32'(cmd_err), 32'd1);
        penable = 1'b0;
        tick();

        // Reset mid-queue discards everything.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        check_reset("midrst");
        render_busy = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(received_op);
        end
        check_eq("midrst_no_issue", 32'(pulses), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
